ctrl_fsm: RTL and testbench

Multicycle control unit for the 16-bit processor. It sits directly upstream of the ALU: it fetches and latches each instruction, decodes it, and drives alu_op, the operand selects and register-file addresses. It consumes the ALU's registered zero flag for branches, and sequences writeback, data-memory access and PC update. One instruction is in flight at a time; there is no pipelining.

---
 rtl/proc_pkg.sv | 67 ++++++
 rtl/instr_decode.sv | 68 ++++++
 rtl/ctrl_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the processor control path.
//   - instruction format widths (IW, RA, IMM_W)
//   - opcode values, ALU operation encodings (also used by the ALU),
//     PC source select encodings
//   - control FSM state encoding and decoded instruction classes
//   - sign_ext_imm(): widens the instruction immediate to IW bits
package proc_pkg;

  localparam int IW    = 16;  // instruction / datapath width
  localparam int RA    = 3;   // register-file address width
  localparam int IMM_W = 6;   // immediate field width

  // Opcodes 0x0-0x7 are R-type; 0xD and 0xE are undefined.
  typedef enum logic [3:0] {
    OP_ADDI = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_JMP  = 4'hC,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_SHR  = 3'b010,
    ALU_SHL  = 3'b011,
    ALU_NAND = 3'b100,
    ALU_OR   = 3'b101,
    ALU_DIR  = 3'b110,
    ALU_SAR  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEL_INC = 2'b00,  // PC + 1
    PC_SEL_BR  = 2'b01,  // PC + 1 + imm
    PC_SEL_JMP = 2'b10   // register-file read port 1
  } pc_sel_t;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_FLAG   = 4'd3,
    ST_BR     = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB     = 4'd6,
    ST_HALT   = 4'd7,
    ST_TRAP   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_JMP     = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  function automatic logic [IW-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(IW-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational decode of the latched instruction.
// Ports:
//   ir        in   IW  latched instruction register
//   op_class  out  3   decoded instruction class (op_class_t encoding)
//   alu_op    out  3   ALU operation to use in EXEC
//   alu_src_b out  1   0 = register port 2, 1 = immediate
//   imm_out   out  IW  sign-extended ir[5:0]
//   rs1       out  RA  ir[8:6]
//   rs2       out  RA  ir[5:3]
//   rd        out  RA  ir[11:9]
module instr_decode
  import proc_pkg::*;
(
  input  logic [IW-1:0] ir,
  output logic [2:0]    op_class,
  output logic [2:0]    alu_op,
  output logic          alu_src_b,
  output logic [IW-1:0] imm_out,
  output logic [RA-1:0] rs1,
  output logic [RA-1:0] rs2,
  output logic [RA-1:0] rd
);

  assign imm_out = sign_ext_imm(ir[IMM_W-1:0]);
  assign rs1     = ir[8:6];
  assign rs2     = ir[5:3];
  assign rd      = ir[11:9];

  // Opcode -> class and ALU controls; memory ops compute rs1+imm, BEQ subtracts
  always_comb begin
    op_class  = CLS_ILLEGAL;
    alu_op    = ALU_DIR;
    alu_src_b = 1'b0;
    if (ir[15] == 1'b0) begin
      // R-type: the low opcode bits are the ALU operation itself
      op_class  = CLS_RTYPE;
      alu_op    = ir[14:12];
      alu_src_b = 1'b0;
    end else begin
      case (ir[15:12])
        OP_ADDI: begin
          op_class  = CLS_ADDI;
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
        end
        OP_LW: begin
          op_class  = CLS_LW;
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
        end
        OP_SW: begin
          op_class  = CLS_SW;
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
        end
        OP_BEQ: begin
          op_class  = CLS_BEQ;
          alu_op    = ALU_SUB;
          alu_src_b = 1'b0;
        end
        OP_JMP:  op_class = CLS_JMP;
        OP_HALT: op_class = CLS_HALT;
        default: op_class = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle control unit of the 16-bit processor.
// Fetches and latches one instruction at a time, decodes it and sequences
// EXEC / FLAG / BR / MEM / WB, driving the ALU, register file, data memory
// and PC controls.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   imem_req/imem_ack   instruction fetch handshake, instr = fetched word
//   dmem_req/dmem_we    data access request (we: 1 = store), dmem_ack done
//   alu_op, alu_src_b   ALU operation and operand-B select
//   imm_out             sign-extended immediate
//   rf_ra1/rf_ra2/rf_wa register-file read/write addresses
//   rf_we, wb_sel       register write strobe, writeback source
//   pc_we, pc_sel       PC update strobe and source
//   z_in                registered ALU zero flag
//   halted, illegal     sticky terminal-state indicators
module ctrl_fsm
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] instr,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic [2:0]    alu_op,
  output logic          alu_src_b,
  output logic [IW-1:0] imm_out,
  output logic [RA-1:0] rf_ra1,
  output logic [RA-1:0] rf_ra2,
  output logic [RA-1:0] rf_wa,
  output logic          rf_we,
  output logic          wb_sel,
  output logic          pc_we,
  output logic [1:0]    pc_sel,
  input  logic          z_in,
  output logic          halted,
  output logic          illegal
);

  state_t        state_r;
  state_t        state_next_s;
  logic [IW-1:0] ir_r;
  logic          halted_r;
  logic          illegal_r;

  logic [2:0]    dec_class_s;
  logic [2:0]    dec_alu_op_s;
  logic          dec_src_b_s;
  logic [IW-1:0] dec_imm_s;
  logic [RA-1:0] dec_rs1_s;
  logic [RA-1:0] dec_rs2_s;
  logic [RA-1:0] dec_rd_s;

  logic          imem_req_s;
  logic          dmem_req_s;
  logic          dmem_we_s;
  logic          rf_we_s;
  logic          wb_sel_s;
  logic          pc_we_s;
  logic [1:0]    pc_sel_s;
  logic [2:0]    alu_op_s;
  logic          alu_src_b_s;
  logic [RA-1:0] rf_ra2_s;

  instr_decode u_decode (
    .ir        (ir_r),
    .op_class  (dec_class_s),
    .alu_op    (dec_alu_op_s),
    .alu_src_b (dec_src_b_s),
    .imm_out   (dec_imm_s),
    .rs1       (dec_rs1_s),
    .rs2       (dec_rs2_s),
    .rd        (dec_rd_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction register: loaded only by an ack that answers our own fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_r <= {IW{1'b0}};
    end else if ((state_r == ST_FETCH) && imem_ack) begin
      ir_r <= instr;
    end
  end

  // Sticky terminal flags, set on the DECODE -> HALT / TRAP transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      if ((state_r == ST_DECODE) && (dec_class_s == CLS_HALT)) begin
        halted_r <= 1'b1;
      end
      if ((state_r == ST_DECODE) && (dec_class_s == CLS_ILLEGAL)) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Next-state and control outputs; ALU controls are held from EXEC onward
  always_comb begin
    state_next_s = state_r;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    rf_we_s      = 1'b0;
    wb_sel_s     = 1'b0;
    pc_we_s      = 1'b0;
    pc_sel_s     = PC_SEL_INC;
    alu_op_s     = ALU_DIR;
    alu_src_b_s  = 1'b0;
    rf_ra2_s     = dec_rs2_s;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (dec_class_s)
          CLS_JMP: begin
            pc_we_s      = 1'b1;
            pc_sel_s     = PC_SEL_JMP;
            state_next_s = ST_FETCH;
          end
          CLS_HALT:    state_next_s = ST_HALT;
          CLS_ILLEGAL: state_next_s = ST_TRAP;
          default:     state_next_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_op_s    = dec_alu_op_s;
        alu_src_b_s = dec_src_b_s;
        // BEQ compares rs1 against rd, so rd goes out on read port 2
        if (dec_class_s == CLS_BEQ) begin
          rf_ra2_s = dec_rd_s;
        end else begin
          rf_ra2_s = dec_rs2_s;
        end
        case (dec_class_s)
          CLS_LW, CLS_SW: state_next_s = ST_MEM;
          CLS_BEQ:        state_next_s = ST_FLAG;
          default:        state_next_s = ST_WB;
        endcase
      end
      ST_FLAG: begin
        // z_in lags the ALU result by one cycle; it is valid in BR
        alu_op_s     = dec_alu_op_s;
        alu_src_b_s  = dec_src_b_s;
        state_next_s = ST_BR;
      end
      ST_BR: begin
        alu_op_s     = dec_alu_op_s;
        alu_src_b_s  = dec_src_b_s;
        pc_we_s      = 1'b1;
        if (z_in) begin
          pc_sel_s = PC_SEL_BR;
        end else begin
          pc_sel_s = PC_SEL_INC;
        end
        state_next_s = ST_FETCH;
      end
      ST_MEM: begin
        alu_op_s    = dec_alu_op_s;
        alu_src_b_s = dec_src_b_s;
        dmem_req_s  = 1'b1;
        dmem_we_s   = (dec_class_s == CLS_SW);
        // Store data comes from rd on read port 2
        if (dec_class_s == CLS_SW) begin
          rf_ra2_s = dec_rd_s;
        end else begin
          rf_ra2_s = dec_rs2_s;
        end
        if (dmem_ack) begin
          if (dec_class_s == CLS_SW) begin
            pc_we_s      = 1'b1;
            pc_sel_s     = PC_SEL_INC;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_WB;
          end
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_WB: begin
        alu_op_s     = dec_alu_op_s;
        alu_src_b_s  = dec_src_b_s;
        rf_we_s      = 1'b1;
        wb_sel_s     = (dec_class_s == CLS_LW);
        pc_we_s      = 1'b1;
        pc_sel_s     = PC_SEL_INC;
        state_next_s = ST_FETCH;
      end
      ST_HALT: state_next_s = ST_HALT;
      ST_TRAP: state_next_s = ST_TRAP;
      default: state_next_s = ST_FETCH;
    endcase
  end

  // Requests and strobes are forced low for the whole reset window, since
  // the state register already reads FETCH while rst is still high.
  assign imem_req  = imem_req_s & ~rst;
  assign dmem_req  = dmem_req_s & ~rst;
  assign rf_we     = rf_we_s & ~rst;
  assign pc_we     = pc_we_s & ~rst;
  assign dmem_we   = dmem_we_s;
  assign wb_sel    = wb_sel_s;
  assign pc_sel    = pc_sel_s;
  assign alu_op    = alu_op_s;
  assign alu_src_b = alu_src_b_s;
  assign imm_out   = dec_imm_s;
  assign rf_ra1    = dec_rs1_s;
  assign rf_ra2    = rf_ra2_s;
  assign rf_wa     = dec_rd_s;
  assign halted    = halted_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm. Each scenario pushes per-cycle stimulus
// together with the expected output snapshot into a queue, then pops the
// entries one cycle at a time, drives them and compares the outputs.
module tb_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] instr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [2:0]  alu_op;
  logic        alu_src_b;
  logic [15:0] imm_out;
  logic [2:0]  rf_ra1;
  logic [2:0]  rf_ra2;
  logic [2:0]  rf_wa;
  logic        rf_we;
  logic        wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        z_in;
  logic        halted;
  logic        illegal;

  ctrl_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .instr     (instr),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .imm_out   (imm_out),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .z_in      (z_in),
    .halted    (halted),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  alu_op;
    logic        alu_src_b;
    logic [15:0] imm_out;
    logic [2:0]  rf_ra1;
    logic [2:0]  rf_ra2;
    logic [2:0]  rf_wa;
    logic        halted;
    logic        illegal;
  } snap_t;

  typedef struct {
    logic        imem_ack;
    logic [15:0] instr;
    logic        dmem_ack;
    logic        z_in;
    snap_t       val;
    snap_t       mask;
  } entry_t;

  entry_t      q[$];
  logic [15:0] cur_ir;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet snapshot for the bench's view of ir: ALU on DIR, no strobes.
  function automatic snap_t base(input logic [15:0] ir);
    snap_t s;
    s = {$bits(snap_t){1'b0}};
    s.alu_op  = 3'b110;
    s.imm_out = {{10{ir[5]}}, ir[5:0]};
    s.rf_ra1  = ir[8:6];
    s.rf_ra2  = ir[5:3];
    s.rf_wa   = ir[11:9];
    return s;
  endfunction

  function automatic snap_t mask_all();
    snap_t m;
    m = {$bits(snap_t){1'b1}};
    return m;
  endfunction

  function automatic snap_t mask_no_src();
    snap_t m;
    m = {$bits(snap_t){1'b1}};
    m.alu_src_b = 1'b0;
    return m;
  endfunction

  function automatic snap_t mask_no_alu();
    snap_t m;
    m = {$bits(snap_t){1'b1}};
    m.alu_src_b = 1'b0;
    m.alu_op    = 3'b000;
    return m;
  endfunction

  function automatic void push(input logic ack, input logic [15:0] ins,
                               input logic dack, input logic z,
                               input snap_t v, input snap_t m);
    entry_t e;
    e.imem_ack = ack;
    e.instr    = ins;
    e.dmem_ack = dack;
    e.z_in     = z;
    e.val      = v;
    e.mask     = m;
    q.push_back(e);
  endfunction

  // FETCH cycle answered by an ack carrying ins
  function automatic void push_fetch(input logic [15:0] ins);
    snap_t s;
    s = base(cur_ir);
    s.imem_req = 1'b1;
    push(1'b1, ins, 1'b0, 1'b0, s, mask_no_src());
    cur_ir = ins;
  endfunction

  // FETCH cycle with no ack
  function automatic void push_idle_fetch();
    snap_t s;
    s = base(cur_ir);
    s.imem_req = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_no_src());
  endfunction

  function automatic void push_decode();
    push(1'b0, 16'h0000, 1'b0, 1'b0, base(cur_ir), mask_no_src());
  endfunction

  // Drive one entry's inputs after the falling edge and sample the outputs.
  task automatic step(input entry_t e, output snap_t obs);
    @(negedge clk);
    imem_ack = e.imem_ack;
    instr    = e.instr;
    dmem_ack = e.dmem_ack;
    z_in     = e.z_in;
    #1;
    obs = {imem_req, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel, alu_op,
           alu_src_b, imm_out, rf_ra1, rf_ra2, rf_wa, halted, illegal};
  endtask

  task automatic test_reset();
    entry_t e;
    snap_t  obs;
    int     idx;
    idx = 0;
    // Acks during reset must be ignored and nothing requested
    push(1'b1, 16'hF000, 1'b1, 1'b0, base(16'h0000), mask_all());
    push(1'b1, 16'hF000, 1'b1, 1'b0, base(16'h0000), mask_all());
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL reset step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst      = 1'b0;
    cur_ir   = 16'h0000;
    // FETCH with no ack waits
    push_idle_fetch();
    push_idle_fetch();
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL reset_release step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_add();
    entry_t e;
    snap_t  obs;
    snap_t  s;
    int     idx;
    idx = 0;
    push_fetch(16'h0298);
    push_decode();
    s = base(cur_ir);
    s.alu_op = 3'b000;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    s.rf_we  = 1'b1;
    s.pc_we  = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL add step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_back_to_back();
    entry_t     e;
    snap_t      obs;
    snap_t      s;
    int         idx;
    logic [3:0] op4;
    idx = 0;
    for (int i = 1; i < 8; i++) begin
      op4 = 4'(i);
      push_fetch({op4, op4[2:0], ~op4[2:0], op4[2:0], 3'b101});
      push_decode();
      s = base(cur_ir);
      s.alu_op = op4[2:0];
      push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
      s.rf_we = 1'b1;
      s.pc_we = 1'b1;
      push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    end
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_addi_neg();
    entry_t e;
    snap_t  obs;
    snap_t  s;
    int     idx;
    idx = 0;
    push_fetch(16'h823F);
    push_decode();
    s = base(cur_ir);
    s.imm_out   = 16'hFFFF;
    s.alu_op    = 3'b000;
    s.alu_src_b = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    s.rf_we = 1'b1;
    s.pc_we = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL addi_neg step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_beq();
    entry_t e;
    snap_t  obs;
    snap_t  s;
    int     idx;
    logic   z;
    idx = 0;
    for (int t = 0; t < 2; t++) begin
      z = (t == 0) ? 1'b1 : 1'b0;
      push_fetch(16'hB243);
      push_decode();
      s = base(cur_ir);
      s.alu_op = 3'b001;
      s.rf_ra2 = 3'd1;
      // z_in is driven opposite to the outcome before BR
      push(1'b0, 16'h0000, 1'b0, ~z, s, mask_all());
      s.rf_ra2 = 3'd0;
      push(1'b0, 16'h0000, 1'b0, ~z, s, mask_all());
      s = base(cur_ir);
      s.imm_out = 16'h0003;
      s.pc_we   = 1'b1;
      s.pc_sel  = z ? 2'b01 : 2'b00;
      push(1'b0, 16'h0000, 1'b0, z, s, mask_no_alu());
    end
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL beq step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_mem();
    entry_t e;
    snap_t  obs;
    snap_t  s;
    int     idx;
    idx = 0;
    // LW with dmem_ack on the third MEM cycle; stray imem_ack in MEM
    push_fetch(16'h9282);
    push_decode();
    s = base(cur_ir);
    s.imm_out   = 16'h0002;
    s.alu_op    = 3'b000;
    s.alu_src_b = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    s.dmem_req = 1'b1;
    push(1'b1, 16'hD000, 1'b0, 1'b0, s, mask_all());
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    push(1'b0, 16'h0000, 1'b1, 1'b0, s, mask_all());
    s.dmem_req = 1'b0;
    s.rf_we    = 1'b1;
    s.wb_sel   = 1'b1;
    s.pc_we    = 1'b1;
    s.rf_wa    = 3'd1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    // SW with immediate ack: store data register rd on port 2 in MEM
    push_fetch(16'hA5C5);
    push_decode();
    s = base(cur_ir);
    s.alu_op    = 3'b000;
    s.alu_src_b = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    s.dmem_req = 1'b1;
    s.dmem_we  = 1'b1;
    s.pc_we    = 1'b1;
    s.rf_ra2   = 3'd2;
    push(1'b0, 16'h0000, 1'b1, 1'b0, s, mask_all());
    // JMP: PC from read port 1 straight out of DECODE
    push_fetch(16'hC1C0);
    s = base(cur_ir);
    s.pc_we  = 1'b1;
    s.pc_sel = 2'b10;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_no_src());
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL mem_jmp step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    entry_t e;
    snap_t  obs;
    snap_t  s;
    int     idx;
    idx = 0;
    push_fetch(16'h9282);
    push_decode();
    s = base(cur_ir);
    s.alu_op    = 3'b000;
    s.alu_src_b = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    s.dmem_req = 1'b1;
    push(1'b0, 16'h0000, 1'b0, 1'b0, s, mask_all());
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL mid_mem step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, dmem_req, rf_we, pc_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_mem_rst_drop: got req/strobes %b expected 0000", {imem_req, dmem_req, rf_we, pc_we});
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    rst      = 1'b0;
    cur_ir   = 16'h0000;
    // Stale dmem_ack after release: FETCH, ir cleared, no strobes
    s = base(cur_ir);
    s.imem_req = 1'b1;
    push(1'b0, 16'h0000, 1'b1, 1'b0, s, mask_no_src());
    push_idle_fetch();
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL mid_mem_release step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_terminal();
    entry_t e;
    snap_t  obs;
    snap_t  s;
    int     idx;
    idx = 0;
    push_fetch(16'hD123);
    push_decode();
    s = base(cur_ir);
    s.illegal = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push(c[0], 16'h0298, c[1], 1'b1, s, mask_no_alu());
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL trap step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst      = 1'b1;
    #1;
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_reset_clear: got illegal=%b expected 0", illegal);
    end
    @(negedge clk);
    rst    = 1'b0;
    cur_ir = 16'h0000;
    push_fetch(16'hF000);
    push_decode();
    s = base(cur_ir);
    s.halted = 1'b1;
    for (int c = 0; c < 6; c++) begin
      push(1'b1, 16'h0298, 1'b1, 1'b0, s, mask_no_alu());
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      idx++;
      step(e, obs);
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL halt step %0d: got %h expected %h mask %h", idx, obs, e.val, e.mask);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur_ir   = 16'h0000;
    rst      = 1'b1;
    imem_ack = 1'b0;
    instr    = 16'h0000;
    dmem_ack = 1'b0;
    z_in     = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_addi_neg();
    test_beq();
    test_mem();
    test_reset_mid_mem();
    test_terminal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
